mem_unit_sync: RTL and testbench
================================

# mem_unit_sync

Clocked, parametrised successor to the CPU's asynchronous byte-array memory. It serves byte, halfword and word loads and stores in big-endian order, with an optional sign-extending load and a programmable wait-state count. Completion is signalled with the same MFC handshake the control unit already consumes. It also adds alignment-fault reporting and back-to-back request acceptance.

## Interface
- DEPTH, 256: memory size in bytes; power of two.
- ADDR_WIDTH, 8: log2(DEPTH); only Address[ADDR_WIDTH-1:0] is used, and higher bits are ignored (addresses wrap modulo DEPTH).
- WAIT_STATES, 5: extra cycles before each access; range 0..15.
- INIT_FILE, "": when non-empty, memory is preloaded with $readmemh at elaboration.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- Enable  in  1  request strobe; sampled only in IDLE.
- ReadWrite  in  1  1 = read, 0 = write.
- Address  in  32  byte address of the access.
- DataIn  in  32  store data, right-justified for byte and halfword.
- wordSelector  in  2  00 = byte, 01 = halfword, 10 = word, 11 = word.
- SignedLoad  in  1  1 = sign-extend byte/halfword loads; 0 = zero-extend.
- DataOut  out  32  last load result, held until the next load completes.
- MFC  out  1  one-cycle completion pulse.
- Busy  out  1  request in flight (WAIT or DONE state).
- AlignFault  out  1  pulses with MFC when the request was misaligned.

## Operation
- States: IDLE, WAIT, DONE.
- IDLE with Enable=1: latch ReadWrite, Address, DataIn, wordSelector and SignedLoad; load the counter with WAIT_STATES; go to WAIT.
- WAIT with counter≠0: decrement. WAIT with counter=0: perform the access, set MFC=1, go to DONE.
- DONE: clear MFC, go to IDLE unconditionally. If Enable is still high, IDLE accepts a new request on the next edge.
- Byte order (big-endian), with A the latched address:
  - word: Mem[A]→[31:24], Mem[A+1]→[23:16], Mem[A+2]→[15:8], Mem[A+3]→[7:0].
  - halfword: Mem[A]→[15:8], Mem[A+1]→[7:0].
  - byte: Mem[A]→[7:0].
- Stores use the same lane mapping from DataIn; untouched bytes are unchanged.
- Loads zero-extend, or sign-extend from bit 7/15 when SignedLoad=1.
- Alignment: a halfword needs A[0]=0; a word needs A[1:0]=0. A misaligned access performs no memory write, leaves DataOut unchanged, and asserts AlignFault together with MFC.
- Byte offsets A+n wrap modulo DEPTH.
- Input changes while Busy=1 are ignored; the latched copies govern the access.
- A store leaves DataOut unchanged.

## Timing
- Reset values: state IDLE, counter 0, DataOut 0, MFC 0, Busy 0, AlignFault 0. Memory contents are not reset.
- Reset mid-request: returns to IDLE on that edge; a pending store is discarded and no MFC is issued.
- Request sampled at edge 0 → Busy=1 after edge 0. The access and MFC occur at edge WAIT_STATES+1. MFC and Busy fall at edge WAIT_STATES+2.
- Throughput with Enable held high: one access per WAIT_STATES+3 cycles.
- DataOut is valid in the same cycle MFC is high and stays stable afterwards.
- Reset and Enable on the same edge: reset wins and the request is not accepted.

## Structure
- Package mem_unit_pkg:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - state typedef {IDLE, WAIT, DONE};
  - READ=1'b1, WRITE=1'b0.
- Sub-module mem_lane_align (combinational): takes the raw bytes, size and SignedLoad and produces the aligned, extended load word plus the misalignment flag. It is instantiated once.

## Test plan
- Word store then load, WAIT_STATES=5: write 32'hDEADBEEF at 0x10, then read word 0x10. Required: DataOut=32'hDEADBEEF; Mem[0x10]=8'hDE, Mem[0x13]=8'hEF; MFC high exactly 6 edges after acceptance, for one cycle.
- Sub-word loads: with Mem[0x20..0x21]=8'h80,8'h7F:
  - signed halfword at 0x20 → 32'hFFFF807F;
  - unsigned byte at 0x20 → 32'h00000080;
  - signed byte at 0x21 → 32'h0000007F.
- Byte store: write 32'h000000AB as a byte at 0x31 over the word 32'h11223344 at 0x30. Required: word read at 0x30 returns 32'h11AB3344.
- Misalignment: word store of 32'h12345678 at 0x42. Required: AlignFault=1 with MFC, memory unchanged, DataOut unchanged.
- Wrap and back-to-back, WAIT_STATES=0: hold Enable high across two word reads at 0xFC and then 0x100 (wraps to 0x00). Required: MFC pulses 3 cycles apart and the second result equals the word at 0x00.
- Reset on the edge where MFC would assert during a store: MFC stays 0, target bytes unchanged, Busy=0 next cycle.

Source files
------------

// File: rtl/mem_unit_pkg.sv
// Shared types and encodings for the clocked byte-addressed memory unit.
// Imported by the lane aligner and the top-level controller.
package mem_unit_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  typedef struct packed {
    logic        rw;
    logic [31:0] data;
    logic [1:0]  size;
    logic        sgn;
  } req_t;

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane selection, load extension and alignment check.
// Purely combinational; raw holds Mem[A..A+3] with Mem[A] in [31:24].
module mem_lane_align
  import mem_unit_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        sgn,
  output logic [31:0] data,
  output logic        misaligned
);

  always_comb begin
    data       = raw;
    misaligned = 1'b0;
    unique case (1'b1)
      size == SZ_BYTE: begin
        data = {{24{sgn & raw[31]}}, raw[31:24]};
      end
      size == SZ_HALF: begin
        data       = {{16{sgn & raw[31]}}, raw[31:16]};
        misaligned = offset[0];
      end
      default: begin
        misaligned = |offset;
      end
    endcase
  end

endmodule

// File: rtl/mem_unit_sync.sv
// Clocked big-endian data memory with wait states and MFC handshake.
// Requests are latched in IDLE; the access happens when the counter drains.
module mem_unit_sync
  import mem_unit_pkg::*;
#(
  parameter int    DEPTH       = 256,
  parameter int    ADDR_WIDTH  = 8,
  parameter int    WAIT_STATES = 5,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Enable,
  input  logic        ReadWrite,
  input  logic [31:0] Address,
  input  logic [31:0] DataIn,
  input  logic [1:0]  wordSelector,
  input  logic        SignedLoad,
  output logic [31:0] DataOut,
  output logic        MFC,
  output logic        Busy,
  output logic        AlignFault
);

  logic [7:0] mem [DEPTH];

  state_t                state;
  logic [3:0]            cnt;
  req_t                  req;
  logic [ADDR_WIDTH-1:0] a0;
  logic [ADDR_WIDTH-1:0] a1;
  logic [ADDR_WIDTH-1:0] a2;
  logic [ADDR_WIDTH-1:0] a3;
  logic [31:0]           raw;
  logic [31:0]           ld;
  logic                  mis;
  logic                  access;
  logic                  unused_addr;

  // Upper address bits are ignored so addresses wrap modulo DEPTH.
  assign unused_addr = ^Address[31:ADDR_WIDTH];

  assign a1     = a0 + ADDR_WIDTH'(1);
  assign a2     = a0 + ADDR_WIDTH'(2);
  assign a3     = a0 + ADDR_WIDTH'(3);
  assign raw    = {mem[a0], mem[a1], mem[a2], mem[a3]};
  assign access = (state == WAIT) && (cnt == 4'd0);

  mem_lane_align u_align (
    .raw        (raw),
    .size       (req.size),
    .offset     (a0[1:0]),
    .sgn        (req.sgn),
    .data       (ld),
    .misaligned (mis)
  );

  // Store path; reset on the access edge discards the pending write.
  always_ff @(posedge clk) begin
    if (!reset && access && req.rw == WRITE && !mis) begin
      unique case (1'b1)
        req.size == SZ_BYTE: begin
          mem[a0] <= req.data[7:0];
        end
        req.size == SZ_HALF: begin
          mem[a0] <= req.data[15:8];
          mem[a1] <= req.data[7:0];
        end
        default: begin
          mem[a0] <= req.data[31:24];
          mem[a1] <= req.data[23:16];
          mem[a2] <= req.data[15:8];
          mem[a3] <= req.data[7:0];
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      req        <= '0;
      a0         <= '0;
      DataOut    <= 32'd0;
      MFC        <= 1'b0;
      Busy       <= 1'b0;
      AlignFault <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (Enable) begin
            req.rw   <= ReadWrite;
            req.data <= DataIn;
            req.size <= wordSelector;
            req.sgn  <= SignedLoad;
            a0       <= Address[ADDR_WIDTH-1:0];
            cnt      <= 4'(WAIT_STATES);
            Busy     <= 1'b1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (req.rw == READ && !mis) DataOut <= ld;
            AlignFault <= mis;
            MFC        <= 1'b1;
            state      <= DONE;
          end
        end
        default: begin
          MFC        <= 1'b0;
          AlignFault <= 1'b0;
          Busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_unit_sync.sv
// Self-checking bench: two instances (5 and 0 wait states) against a
// byte-array reference model, directed cases then random traffic.
module tb_mem_unit_sync;

  logic        clk = 1'b0;
  logic        reset;
  logic        en5;
  logic        en0;
  logic        rw;
  logic [31:0] addr;
  logic [31:0] din;
  logic [1:0]  sz;
  logic        sgn;
  logic [31:0] do5, do0;
  logic        mfc5, mfc0;
  logic        busy5, busy0;
  logic        af5, af0;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0]  mm [2][256];
  logic [31:0] exp_do [2];

  always #5 clk = ~clk;

  mem_unit_sync #(.WAIT_STATES(5)) dut (
    .clk(clk), .reset(reset), .Enable(en5), .ReadWrite(rw),
    .Address(addr), .DataIn(din), .wordSelector(sz), .SignedLoad(sgn),
    .DataOut(do5), .MFC(mfc5), .Busy(busy5), .AlignFault(af5)
  );

  mem_unit_sync #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .Enable(en0), .ReadWrite(rw),
    .Address(addr), .DataIn(din), .wordSelector(sz), .SignedLoad(sgn),
    .DataOut(do0), .MFC(mfc0), .Busy(busy0), .AlignFault(af0)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit model_mis(input logic [31:0] a, input logic [1:0] s);
    int n = nbytes(s);
    return (n > 1) && ((int'(a[7:0]) % n) != 0);
  endfunction

  function automatic logic [31:0] model_load(input int inst,
      input logic [31:0] a, input logic [1:0] s, input bit sg);
    int n = nbytes(s);
    longint v = 0;
    for (int i = 0; i < n; i++)
      v = v * 256 + longint'(mm[inst][(int'(a[7:0]) + i) % 256]);
    if (sg && n < 4 && v >= (longint'(1) << (8 * n - 1)))
      v -= (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic model_store(input int inst, input logic [31:0] a,
                             input logic [1:0] s, input logic [31:0] d);
    int n = nbytes(s);
    for (int i = 0; i < n; i++)
      mm[inst][(int'(a[7:0]) + i) % 256] = 8'((d >> (8 * (n - 1 - i))) & 255);
  endtask

  // One complete request, with inputs scrambled while the unit is busy.
  task automatic req(input int inst, input logic r, input logic [31:0] a,
                     input logic [31:0] d, input logic [1:0] s, input logic sg);
    int  n   = 0;
    bit  got = 0;
    bit  m;
    int  lat = (inst == 0) ? 6 : 1;
    @(negedge clk);
    rw = r; addr = a; din = d; sz = s; sgn = sg;
    if (inst == 0) en5 = 1'b1; else en0 = 1'b1;
    @(negedge clk);
    en5 = 1'b0; en0 = 1'b0;
    rw = ~r; addr = $urandom; din = $urandom;
    sz = 2'($urandom); sgn = ~sg;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n++;
      if ((inst == 0) ? mfc5 : mfc0) got = 1;
    end
    chk("latency", got ? n : 999, lat);
    m = model_mis(a, s);
    if (!m && r) exp_do[inst] = model_load(inst, a, s, sg);
    if (!m && !r) model_store(inst, a, s, d);
    chk("dataout", (inst == 0) ? do5 : do0, exp_do[inst]);
    chk("alignfault", {31'd0, (inst == 0) ? af5 : af0}, {31'd0, m});
    @(posedge clk); #1;
    chk("mfc_fall", {31'd0, (inst == 0) ? mfc5 : mfc0}, 32'd0);
    chk("busy_fall", {31'd0, (inst == 0) ? busy5 : busy0}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; en5 = 1'b0; en0 = 1'b0;
    rw = 1'b1; addr = '0; din = '0; sz = 2'b10; sgn = 1'b0;
    exp_do[0] = '0; exp_do[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dataout", do5, 32'd0);
    chk("rst_mfc", {31'd0, mfc5}, 32'd0);
    chk("rst_busy", {31'd0, busy5}, 32'd0);
    chk("rst_af", {31'd0, af5}, 32'd0);
    @(negedge clk); reset = 1'b0;

    for (int i = 0; i < 128; i += 4)
      req(0, 1'b0, 32'(i), $urandom, 2'b10, 1'b0);
    req(1, 1'b0, 32'hFC, 32'h0BADC0DE, 2'b10, 1'b0);
    req(1, 1'b0, 32'h00, 32'h5EED1234, 2'b10, 1'b0);

    // Word store then load.
    req(0, 1'b0, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0);
    req(0, 1'b1, 32'h10, 32'h0, 2'b10, 1'b0);
    chk("word_rd", do5, 32'hDEADBEEF);
    req(0, 1'b1, 32'h10, 32'h0, 2'b00, 1'b0);
    chk("byte_10", do5, 32'h000000DE);
    req(0, 1'b1, 32'h13, 32'h0, 2'b00, 1'b0);
    chk("byte_13", do5, 32'h000000EF);

    // Sub-word loads.
    req(0, 1'b0, 32'h20, 32'h0000807F, 2'b01, 1'b0);
    req(0, 1'b1, 32'h20, 32'h0, 2'b01, 1'b1);
    chk("half_signed", do5, 32'hFFFF807F);
    req(0, 1'b1, 32'h20, 32'h0, 2'b00, 1'b0);
    chk("byte_unsigned", do5, 32'h00000080);
    req(0, 1'b1, 32'h21, 32'h0, 2'b00, 1'b1);
    chk("byte_signed", do5, 32'h0000007F);

    // Byte store inside a word.
    req(0, 1'b0, 32'h30, 32'h11223344, 2'b10, 1'b0);
    req(0, 1'b0, 32'h31, 32'h000000AB, 2'b00, 1'b0);
    req(0, 1'b1, 32'h30, 32'h0, 2'b10, 1'b0);
    chk("byte_merge", do5, 32'h11AB3344);

    // Misaligned word store.
    req(0, 1'b0, 32'h42, 32'h12345678, 2'b10, 1'b0);
    chk("mis_dataout", do5, 32'h11AB3344);
    req(0, 1'b1, 32'h40, 32'h0, 2'b10, 1'b0);
    req(0, 1'b1, 32'h44, 32'h0, 2'b10, 1'b0);

    // Back-to-back with wrap on the zero-wait instance.
    @(negedge clk);
    rw = 1'b1; addr = 32'hFC; sz = 2'b10; sgn = 1'b0; en0 = 1'b1;
    @(negedge clk);
    addr = 32'h100;
    @(posedge clk); #1;
    chk("b2b_mfc1", {31'd0, mfc0}, 32'd1);
    chk("b2b_data1", do0, 32'h0BADC0DE);
    @(posedge clk); #1;
    chk("b2b_gap1", {31'd0, mfc0}, 32'd0);
    @(posedge clk); #1;
    chk("b2b_gap2", {31'd0, mfc0}, 32'd0);
    chk("b2b_busy", {31'd0, busy0}, 32'd1);
    @(negedge clk); en0 = 1'b0;
    @(posedge clk); #1;
    chk("b2b_mfc2", {31'd0, mfc0}, 32'd1);
    chk("b2b_wrap", do0, 32'h5EED1234);
    exp_do[1] = 32'h5EED1234;
    @(posedge clk);

    // Reset on the edge where the store would complete.
    @(negedge clk);
    rw = 1'b0; addr = 32'h50; din = 32'hCAFEF00D; sz = 2'b10; en5 = 1'b1;
    @(negedge clk); en5 = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_mfc", {31'd0, mfc5}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy5}, 32'd0);
    chk("rst_mid_do", do5, 32'd0);
    chk("rst_mid_do0", do0, 32'd0);
    exp_do[0] = '0; exp_do[1] = '0;
    @(negedge clk); reset = 1'b0;
    req(0, 1'b1, 32'h50, 32'h0, 2'b10, 1'b0);

    // Reset and Enable together.
    @(negedge clk); reset = 1'b1; en5 = 1'b1; rw = 1'b1;
    @(posedge clk); #1;
    chk("rst_en_busy", {31'd0, busy5}, 32'd0);
    @(negedge clk); reset = 1'b0; en5 = 1'b0;
    @(posedge clk); #1;
    chk("rst_en_idle", {31'd0, busy5}, 32'd0);
    exp_do[0] = '0; exp_do[1] = '0;

    // Random traffic.
    for (int i = 0; i < 60; i++)
      req(0, 1'($urandom), 32'($urandom_range(0, 123)) | (32'($urandom) << 8),
          $urandom, 2'($urandom), 1'($urandom));
    for (int i = 0; i < 20; i++)
      req(1, 1'($urandom), (i % 2 == 0) ? 32'hFC + 32'($urandom_range(0, 3))
          : 32'($urandom_range(0, 3)), $urandom, 2'($urandom), 1'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
